regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of a register file: two requesters share one write port.
// Define REGFILE_WB_ARBITER_BYPASS_EN to forward the write stage onto the read data outputs.
module regfile_wb_arbiter #(
    parameter int unsigned REG_WIDTH = 64,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [$clog2(NUM_REGS)-1:0] req0_reg,
    input  logic [REG_WIDTH-1:0]        req0_data,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [$clog2(NUM_REGS)-1:0] req1_reg,
    input  logic [REG_WIDTH-1:0]        req1_data,
    output logic                        RegWrite,
    output logic [$clog2(NUM_REGS)-1:0] WriteRegister,
    output logic [REG_WIDTH-1:0]        WriteData,
    input  logic [$clog2(NUM_REGS)-1:0] ReadRegister1,
    input  logic [$clog2(NUM_REGS)-1:0] ReadRegister2,
    input  logic [REG_WIDTH-1:0]        rf_data1,
    input  logic [REG_WIDTH-1:0]        rf_data2,
    output logic [REG_WIDTH-1:0]        ReadData1,
    output logic [REG_WIDTH-1:0]        ReadData2
);

    localparam int unsigned      AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0]    ZERO_REG = AW'(NUM_REGS - 1);

    logic                 last_grant;  // 1: req1 won the most recent transfer
    logic                 grant0;
    logic                 grant1;
    logic                 xfer;
    logic [AW-1:0]        sel_reg;
    logic [REG_WIDTH-1:0] sel_data;

    // Grant selection; the requester that did not win last has priority under contention
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign sel_reg    = grant1 ? req1_reg  : req0_reg;
    assign sel_data   = grant1 ? req1_data : req0_data;

    // Write stage; writes to the hardwired-zero register are accepted but suppressed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant    <= 1'b1;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= xfer && (sel_reg != ZERO_REG);
            if (xfer) begin
                last_grant    <= grant1;
                WriteRegister <= sel_reg;
                WriteData     <= sel_data;
            end
        end
    end

`ifdef REGFILE_WB_ARBITER_BYPASS_EN
    // Forward the in-flight write to a matching read port
    always_comb begin
        ReadData1 = rf_data1;
        ReadData2 = rf_data2;
        if (RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_REG)) begin
            ReadData1 = WriteData;
        end
        if (RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_REG)) begin
            ReadData2 = WriteData;
        end
    end
`else
    logic unused_rd_addr;

    assign ReadData1      = rf_data1;
    assign ReadData2      = rf_data2;
    assign unused_rd_addr = ^{ReadRegister1, ReadRegister2};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: driver pushes expected writes, a monitor checks the write port.
module tb_regfile_wb_arbiter;

    localparam int unsigned RW = 64;
    localparam int unsigned AW = 5;

`ifdef REGFILE_WB_ARBITER_BYPASS_EN
    localparam logic [RW-1:0] BYP_EXP = 64'h1234;
`else
    localparam logic [RW-1:0] BYP_EXP = 64'h0;
`endif

    typedef struct packed {
        int unsigned   cyc;
        logic [AW-1:0] r;
        logic [RW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_reg, req1_reg;
    logic [RW-1:0] req0_data, req1_data;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [RW-1:0] WriteData;
    logic [AW-1:0] ReadRegister1, ReadRegister2;
    logic [RW-1:0] rf_data1, rf_data2;
    logic [RW-1:0] ReadData1, ReadData2;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];

    regfile_wb_arbiter #(.REG_WIDTH(64), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One driven cycle with hand-computed grants; accepted non-zero writes are expected next cycle
    task automatic do_cycle(input logic v0, input logic [AW-1:0] r0, input logic [RW-1:0] d0,
                            input logic v1, input logic [AW-1:0] r1, input logic [RW-1:0] d1,
                            input logic e0, input logic e1, input string name);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        @(negedge clk);
        check({name, "_ready0"}, 64'(req0_ready), 64'(e0));
        check({name, "_ready1"}, 64'(req1_ready), 64'(e1));
        if (e0 && r0 != 5'd31) exp_q.push_back('{cyc: cyc + 1, r: r0, d: d0});
        if (e1 && r1 != 5'd31) exp_q.push_back('{cyc: cyc + 1, r: r1, d: d1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic read_cycle(input logic [AW-1:0] rr1, input logic [RW-1:0] rd1,
                              input logic [AW-1:0] rr2, input logic [RW-1:0] rd2,
                              input logic [RW-1:0] exp1, input logic [RW-1:0] exp2, input string name);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        ReadRegister1 = rr1; rf_data1 = rd1;
        ReadRegister2 = rr2; rf_data2 = rd2;
        @(negedge clk);
        check({name, "_rd1"}, ReadData1, exp1);
        check({name, "_rd2"}, ReadData2, exp2);
    endtask

    // Monitor: compares the write port against the scoreboard every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("rst_regwrite", 64'(RegWrite), 64'h0);
                check("rst_wreg", 64'(WriteRegister), 64'h0);
                check("rst_wdata", WriteData, 64'h0);
                check("rst_readies", 64'({req0_ready, req1_ready}), 64'h0);
                exp_q.delete();
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    check("missed_write", 64'(RegWrite), 64'h1);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check("wb_regwrite", 64'(RegWrite), 64'h1);
                    check("wb_reg", 64'(WriteRegister), 64'(e.r));
                    check("wb_data", WriteData, e.d);
                end else begin
                    check("idle_regwrite", 64'(RegWrite), 64'h0);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        req0_valid = 1'b1; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b1; req1_reg = '0; req1_data = '0;
        ReadRegister1 = '0; ReadRegister2 = '0; rf_data1 = '0; rf_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Contention out of reset: req0, req1, req0, req1 with loser held stable
        do_cycle(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 1, 0, "cont1");
        do_cycle(1, 5'd3, 64'h33, 1, 5'd2, 64'h22, 0, 1, "cont2");
        do_cycle(1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 0, "cont3");
        do_cycle(1, 5'd5, 64'h55, 1, 5'd4, 64'h44, 0, 1, "cont4");
        idle(2);

        do_cycle(1, 5'd5, 64'hA5, 0, 5'd0, 64'h0, 1, 0, "single0");
        idle(2);
        do_cycle(0, 5'd0, 64'h0, 1, 5'd9, 64'h99, 0, 1, "single1");

        // Hardwired-zero register: handshake but no write, then a normal write
        do_cycle(0, 5'd0, 64'h0, 1, 5'd31, 64'hFF, 0, 1, "zero_reg");
        do_cycle(1, 5'd3, 64'h77, 0, 5'd0, 64'h0, 1, 0, "after_zero");
        idle(1);

        // last grant was req0, so req1 wins this contention
        do_cycle(1, 5'd10, 64'h100, 1, 5'd11, 64'h111, 0, 1, "rr_a");
        do_cycle(1, 5'd10, 64'h100, 0, 5'd0, 64'h0, 1, 0, "rr_b");
        idle(1);

        // Reset in the cycle after a transfer, with valids high during reset
        do_cycle(1, 5'd12, 64'hC, 0, 5'd0, 64'h0, 1, 0, "rst_pre");
        @(posedge clk);
        #1;
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        idle(1);
        do_cycle(1, 5'd13, 64'hD0, 1, 5'd14, 64'hE0, 1, 0, "post_rst_a");
        do_cycle(0, 5'd0, 64'h0, 1, 5'd14, 64'hE0, 0, 1, "post_rst_b");
        idle(1);

        // Read path: bypass of reg 7 only in the bypass build; reg 31 never bypassed
        do_cycle(1, 5'd7, 64'h1234, 0, 5'd0, 64'h0, 1, 0, "byp_wr");
        read_cycle(5'd7, 64'h0, 5'd31, 64'hBEEF, BYP_EXP, 64'hBEEF, "byp");
        read_cycle(5'd7, 64'h55, 5'd31, 64'hBEEF, 64'h55, 64'hBEEF, "passthru");
        do_cycle(1, 5'd31, 64'h999, 0, 5'd0, 64'h0, 1, 0, "byp_zero_wr");
        read_cycle(5'd31, 64'h66, 5'd2, 64'h88, 64'h66, 64'h88, "zero_rd");

        idle(3);
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
